// File: rtl/sample_rate_bridge_if.sv
// ============================================================================
// Module      : sample_rate_bridge_if
// Description : Producer/consumer signal bundle for sample_rate_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sample_rate_bridge_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
);
  logic             hold_mode;
  logic             in_stb;
  logic [WIDTH-1:0] in_data;
  logic             out_ready;
  logic             clr_ovf;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [AW:0]      level;
  logic             overflow;

  modport master (
    output hold_mode, in_stb, in_data, out_ready, clr_ovf,
    input  out_valid, out_data, level, overflow
  );

  modport slave (
    input  hold_mode, in_stb, in_data, out_ready, clr_ovf,
    output out_valid, out_data, level, overflow
  );
endinterface

`default_nettype wire

// File: rtl/sample_rate_bridge.sv
// ============================================================================
// Module      : sample_rate_bridge
// Description : Strobed-sample bridge: FIFO stream mode or hold-latest mode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_rate_bridge #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  sample_rate_bridge_if.slave bus
);

  localparam logic [AW:0]   c_full    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   c_lvl_one = (AW+1)'(1);
  localparam logic [AW-1:0] c_ptr_one = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic [WIDTH-1:0] hold_reg_q, hold_reg_d;
  logic             hold_valid_q, hold_valid_d;
  logic             overflow_q, overflow_d;
  logic             mode_q, mode_d;

  logic             w_flush;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_ovf_set;
  logic             w_out_valid;

  always_comb begin
    w_flush   = bus.hold_mode != mode_q;
    w_full    = level_q == c_full;
    w_pop     = !bus.hold_mode && !w_flush && (level_q != '0) && bus.out_ready;
    w_push    = !bus.hold_mode && !w_flush && bus.in_stb && (!w_full || w_pop);
    w_ovf_set = !bus.hold_mode && !w_flush && bus.in_stb && w_full && !w_pop;

    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    level_d      = level_q;
    hold_reg_d   = hold_reg_q;
    hold_valid_d = hold_valid_q;
    mode_d       = bus.hold_mode;

    if (w_flush) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      level_d      = '0;
      hold_valid_d = 1'b0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + c_ptr_one;
      if (w_pop)  rd_ptr_d = rd_ptr_q + c_ptr_one;
      case ({w_push, w_pop})
        2'b10:   level_d = level_q + c_lvl_one;
        2'b01:   level_d = level_q - c_lvl_one;
        default: level_d = level_q;
      endcase
      if (bus.hold_mode && bus.in_stb) begin
        hold_reg_d   = bus.in_data;
        hold_valid_d = 1'b1;
      end
    end

    // A drop in the same cycle as a clear must stay visible.
    if (w_ovf_set)        overflow_d = 1'b1;
    else if (bus.clr_ovf) overflow_d = 1'b0;
    else                  overflow_d = overflow_q;
  end

  always_ff @(posedge clk) begin
    mode_q <= mode_d;
    if (!rst_n) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      level_q      <= '0;
      hold_reg_q   <= '0;
      hold_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      level_q      <= level_d;
      hold_reg_q   <= hold_reg_d;
      hold_valid_q <= hold_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= bus.in_data;
  end

  always_comb begin
    w_out_valid   = bus.hold_mode ? hold_valid_q : (level_q != '0);
    bus.out_valid = w_out_valid;
    if (!w_out_valid)      bus.out_data = '0;
    else if (bus.hold_mode) bus.out_data = hold_reg_q;
    else                   bus.out_data = mem_q[rd_ptr_q];
    bus.level    = bus.hold_mode ? '0 : level_q;
    bus.overflow = overflow_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_sample_rate_bridge.sv
// ============================================================================
// Module      : tb_sample_rate_bridge
// Description : Directed + random stimulus against a queue-based reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sample_rate_bridge;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic clk;
  logic rst_n;

  sample_rate_bridge_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) bus ();

  sample_rate_bridge #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: FIFO contents as a queue, plus hold-mode register.
  logic [WIDTH-1:0] m_fifo [$];
  logic [WIDTH-1:0] m_hold;
  logic             m_hold_valid;
  logic             m_ovf;
  logic             m_prev_mode;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic rst, input logic mode, input logic stb,
                       input logic [WIDTH-1:0] data, input logic rdy, input logic clr);
    logic             exp_valid;
    logic [WIDTH-1:0] exp_data;
    int               exp_level;
    logic             can_pop;
    rst_n         = rst;
    bus.hold_mode = mode;
    bus.in_stb    = stb;
    bus.in_data   = data;
    bus.out_ready = rdy;
    bus.clr_ovf   = clr;
    @(negedge clk);
    exp_valid = mode ? m_hold_valid : (m_fifo.size() != 0);
    exp_data  = !exp_valid ? '0 : (mode ? m_hold : m_fifo[0]);
    exp_level = mode ? 0 : m_fifo.size();
    check("out_valid", 64'(bus.out_valid), 64'(exp_valid));
    check("out_data",  64'(bus.out_data),  64'(exp_data));
    check("level",     64'(bus.level),     64'(exp_level));
    check("overflow",  64'(bus.overflow),  64'(m_ovf));
    @(posedge clk);
    if (!rst) begin
      m_fifo.delete();
      m_hold       = '0;
      m_hold_valid = 1'b0;
      m_ovf        = 1'b0;
    end else if (mode != m_prev_mode) begin
      m_fifo.delete();
      m_hold_valid = 1'b0;
      if (clr) m_ovf = 1'b0;
    end else if (mode) begin
      if (stb) begin
        m_hold       = data;
        m_hold_valid = 1'b1;
      end
      if (clr) m_ovf = 1'b0;
    end else begin
      can_pop = (m_fifo.size() != 0) && rdy;
      if (can_pop) void'(m_fifo.pop_front());
      if (stb && m_fifo.size() < DEPTH) begin
        m_fifo.push_back(data);
        if (clr) m_ovf = 1'b0;
      end else if (stb) begin
        m_ovf = 1'b1;
      end else if (clr) begin
        m_ovf = 1'b0;
      end
    end
    m_prev_mode = mode;
    #1;
  endtask

  initial begin
    logic mode;
    m_hold       = '0;
    m_hold_valid = 1'b0;
    m_ovf        = 1'b0;
    m_prev_mode  = 1'b0;
    rst_n         = 1'b0;
    bus.hold_mode = 1'b0;
    bus.in_stb    = 1'b1;
    bus.in_data   = 32'hDEAD_BEEF;
    bus.out_ready = 1'b0;
    bus.clr_ovf   = 1'b0;
    @(posedge clk);
    #1;

    // Reset held with strobes active
    repeat (3) cycle(1'b0, 1'b0, 1'b1, $urandom, 1'b1, 1'b0);

    // Stream ordering: fill to DEPTH, then drain
    for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b0, 1'b1, 32'hA0 + i, 1'b0, 1'b0);
    repeat (5) cycle(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);

    // Full boundary: drop, accept-with-pop, clear racing a drop
    for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b0, 1'b1, 32'hB0 + i, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 32'h55, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 32'h55, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 32'h66, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    repeat (5) cycle(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);

    // Pointer wrap with sparse strobes
    for (int i = 0; i < 30; i++)
      cycle(1'b1, 1'b0, (i % 3) == 0, 32'hC00 + i, 1'b1, 1'b0);

    // Hold mode: last strobe wins, out_ready ignored
    cycle(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 32'h11, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 32'h22, 1'b0, 1'b0);
    repeat (2) cycle(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);

    // Mode switch with level=3 and a strobe in the switch cycle
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) cycle(1'b1, 1'b0, 1'b1, 32'hD0 + i, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 32'h77, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 32'h88, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);

    // Mid-operation reset with data buffered
    cycle(1'b1, 1'b0, 1'b1, 32'hE1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'hE2, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);

    // Random traffic
    mode = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(63) == 0) mode = ~mode;
      cycle($urandom_range(199) != 0, mode, $urandom_range(1) == 1, $urandom,
            $urandom_range(2) != 0, $urandom_range(15) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
